nyq_upsampler: RTL and testbench

- Symbol-rate to sample-rate zero-stuffing interpolator; sits directly upstream of the NYQ pulse-shaping filter.
- Accepts one symbol per valid/ready handshake and buffers it in a 2-entry FIFO.
- Emits one sample every clock into `NYQ_In_DI`: the symbol on phase 0, zero on the remaining L-1 phases.
- The factor L is programmed over the same parameter bus (`WrEn`/`Addr`/`PAR_In`) that loads the NYQ coefficients.

---
 rtl/nyq_upsampler.sv | 192 +++++++++++++++++++
 tb/tb_nyq_upsampler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nyq_upsampler.sv
// Zero-stuffing interpolator feeding the NYQ pulse-shaping filter: 2-entry symbol FIFO,
// L programmed on the parameter bus. Define UPS_ZOH_EN for zero-order hold instead of zero stuffing.
module nyq_upsampler #(
   parameter int ADDR_WIDTH = 6,
   parameter int MEM_WIDTH  = 24,
   parameter int IN_WIDTH   = 24,
   parameter int OUT_WIDTH  = 24,
   parameter int L_WIDTH    = 4,
   parameter int UPS_ADDR   = 63,
   parameter int L_DEFAULT  = 4
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  WrEn_SI,
   input  logic [ADDR_WIDTH-1:0] Addr_DI,
   input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
   input  logic [IN_WIDTH-1:0]   UPS_In_DI,
   input  logic                  UPS_Valid_SI,
   output logic                  UPS_Ready_SO,
   output logic [OUT_WIDTH-1:0]  UPS_Out_DO,
   output logic                  UPS_Strobe_SO,
   output logic                  UPS_Underrun_SO
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LP_UPS_ADDR  = ADDR_WIDTH'(UPS_ADDR);
   localparam logic [L_WIDTH-1:0]    LP_L_DEFAULT = L_WIDTH'(L_DEFAULT);

   logic [IN_WIDTH-1:0]  r_mem [2];
   logic                 r_wptr;
   logic                 r_rptr;
   logic [1:0]           r_count;
   logic                 r_ready;
   logic [L_WIDTH-1:0]   r_l_reg;
   logic [L_WIDTH-1:0]   r_l_act;
   logic [L_WIDTH-1:0]   r_phase;
   state_t               r_state;
   logic [OUT_WIDTH-1:0] r_out;
   logic                 r_strobe;
   logic                 r_underrun;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_cfg_wr;
   logic [1:0]           w_count_nxt;
   logic [IN_WIDTH-1:0]  w_head;
   logic [OUT_WIDTH-1:0] w_head_ext;
   logic [L_WIDTH-1:0]   w_l_new_eff;
   logic [L_WIDTH-1:0]   w_l_act_last;
   logic                 w_unused_par;

   // L of 0 or 1 both mean pass-through
   function automatic logic [L_WIDTH-1:0] eff_l(input logic [L_WIDTH-1:0] l);
      if (l <= L_WIDTH'(1)) begin
         eff_l = L_WIDTH'(1);
      end else begin
         eff_l = l;
      end
   endfunction

   assign w_unused_par = ^PAR_In_DI[MEM_WIDTH-1:L_WIDTH];
   assign w_cfg_wr     = WrEn_SI && (Addr_DI == LP_UPS_ADDR);
   assign w_push       = UPS_Valid_SI && r_ready;
   assign w_head       = r_mem[r_rptr];
   assign w_head_ext   = OUT_WIDTH'($signed(w_head));
   assign w_l_new_eff  = eff_l(r_l_reg);
   assign w_l_act_last = eff_l(r_l_act) - L_WIDTH'(1);

   // Pop decision: a symbol leaves the FIFO only on a phase-0 boundary
   always_comb begin
      w_pop = 1'b0;
      if ((r_count != 2'd0) && (r_phase == L_WIDTH'(0))) begin
         w_pop = 1'b1;
      end else begin
         w_pop = 1'b0;
      end
   end

   // Next FIFO occupancy
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Symbol FIFO storage, pointers and registered ready
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= UPS_In_DI;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < 2'd2);
      end
   end

   // Parameter-bus L register
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_l_reg <= LP_L_DEFAULT;
      end else if (w_cfg_wr) begin
         r_l_reg <= PAR_In_DI[L_WIDTH-1:0];
      end else begin
         r_l_reg <= r_l_reg;
      end
   end

   // Phase sequencer with registered sample, strobe and sticky underrun
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_state    <= ST_IDLE;
         r_phase    <= L_WIDTH'(0);
         r_l_act    <= LP_L_DEFAULT;
         r_out      <= '0;
         r_strobe   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_cfg_wr) begin
            r_underrun <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (r_count != 2'd0) begin
                  r_out    <= w_head_ext;
                  r_strobe <= 1'b1;
                  r_l_act  <= r_l_reg;
                  r_phase  <= (w_l_new_eff == L_WIDTH'(1)) ? L_WIDTH'(0) : L_WIDTH'(1);
                  r_state  <= ST_RUN;
               end else begin
                  r_out    <= '0;
                  r_strobe <= 1'b0;
                  r_phase  <= L_WIDTH'(0);
                  r_state  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (r_phase != L_WIDTH'(0)) begin
`ifdef UPS_ZOH_EN
                  r_out <= r_out;
`else
                  r_out <= '0;
`endif
                  r_strobe <= 1'b0;
                  r_phase  <= (r_phase >= w_l_act_last) ? L_WIDTH'(0) : (r_phase + L_WIDTH'(1));
               end else if (r_count != 2'd0) begin
                  r_out    <= w_head_ext;
                  r_strobe <= 1'b1;
                  r_l_act  <= r_l_reg;
                  r_phase  <= (w_l_new_eff == L_WIDTH'(1)) ? L_WIDTH'(0) : L_WIDTH'(1);
               end else begin
                  // Starved at a period boundary: flag it and park until the next symbol
                  r_out      <= '0;
                  r_strobe   <= 1'b0;
                  r_underrun <= 1'b1;
                  r_phase    <= L_WIDTH'(0);
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_out    <= '0;
               r_strobe <= 1'b0;
               r_phase  <= L_WIDTH'(0);
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign UPS_Ready_SO    = r_ready;
   assign UPS_Out_DO      = r_out;
   assign UPS_Strobe_SO   = r_strobe;
   assign UPS_Underrun_SO = r_underrun;

endmodule

// File: tb/tb_nyq_upsampler.sv
// Randomized and directed bench for nyq_upsampler against a queue-based reference model.
module tb_nyq_upsampler;

   logic        clk;
   logic        rst_n;
   logic        wren;
   logic [5:0]  addr;
   logic [23:0] par;
   logic [23:0] din;
   logic        valid;
   logic        ready;
   logic [23:0] dout;
   logic        strobe;
   logic        underrun;

   int errors = 0;
   int checks = 0;

   logic [23:0] q[$];
   int          m_l;
   bit          m_run;
   int          m_rem;
   logic [23:0] m_out;
   logic [23:0] m_last;
   bit          m_strobe;
   bit          m_underrun;
   bit          m_ready;

   nyq_upsampler dut (
      .Clk_CI          (clk),
      .Rst_RBI         (rst_n),
      .WrEn_SI         (wren),
      .Addr_DI         (addr),
      .PAR_In_DI       (par),
      .UPS_In_DI       (din),
      .UPS_Valid_SI    (valid),
      .UPS_Ready_SO    (ready),
      .UPS_Out_DO      (dout),
      .UPS_Strobe_SO   (strobe),
      .UPS_Underrun_SO (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff(input int l);
      return (l <= 1) ? 1 : l;
   endfunction

   task automatic model_reset();
      q.delete();
      m_l        = 4;
      m_run      = 1'b0;
      m_rem      = 0;
      m_out      = 24'd0;
      m_last     = 24'd0;
      m_strobe   = 1'b0;
      m_underrun = 1'b0;
      m_ready    = 1'b0;
   endtask

   task automatic model_edge(input bit v, input logic [23:0] d, input bit wr,
                             input logic [5:0] a, input logic [23:0] p);
      bit set_ur;
      bit accept;
      bit l_wr;
      set_ur   = 1'b0;
      accept   = v && m_ready;
      l_wr     = wr && (a == 6'd63);
      m_strobe = 1'b0;
      if (!m_run) begin
         if (q.size() > 0) begin
            m_out    = q.pop_front();
            m_last   = m_out;
            m_strobe = 1'b1;
            m_run    = 1'b1;
            m_rem    = eff(m_l) - 1;
         end else begin
            m_out = 24'd0;
         end
      end else if (m_rem > 0) begin
`ifdef UPS_ZOH_EN
         m_out = m_last;
`else
         m_out = 24'd0;
`endif
         m_rem = m_rem - 1;
      end else if (q.size() > 0) begin
         m_out    = q.pop_front();
         m_last   = m_out;
         m_strobe = 1'b1;
         m_rem    = eff(m_l) - 1;
      end else begin
         m_out  = 24'd0;
         set_ur = 1'b1;
         m_run  = 1'b0;
      end
      if (l_wr) m_l = int'(p[3:0]);
      if (set_ur) m_underrun = 1'b1;
      else if (l_wr) m_underrun = 1'b0;
      if (accept) q.push_back(d);
      m_ready = (q.size() < 2);
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (dout === m_out) else begin
         errors++;
         $error("FAIL %s out: got %0d expected %0d", tag, $signed(dout), $signed(m_out));
      end
      checks++;
      assert (strobe === m_strobe) else begin
         errors++;
         $error("FAIL %s strobe: got %0b expected %0b", tag, strobe, m_strobe);
      end
      checks++;
      assert (underrun === m_underrun) else begin
         errors++;
         $error("FAIL %s underrun: got %0b expected %0b", tag, underrun, m_underrun);
      end
      checks++;
      assert (ready === m_ready) else begin
         errors++;
         $error("FAIL %s ready: got %0b expected %0b", tag, ready, m_ready);
      end
   endtask

   task automatic step(input string tag, input bit v, input logic [23:0] d,
                       input bit wr, input logic [5:0] a, input logic [23:0] p);
      valid = v;
      din   = d;
      wren  = wr;
      addr  = a;
      par   = p;
      @(posedge clk);
      model_edge(v, d, wr, a, p);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      assert (dout === 24'd0 && strobe === 1'b0 && underrun === 1'b0 && ready === 1'b0) else begin
         errors++;
         $error("FAIL %s: got out=%0d strb=%0b ur=%0b rdy=%0b expected all zero",
                tag, dout, strobe, underrun, ready);
      end
   endtask

   initial begin
      logic signed [23:0] exp1 [14];
      logic [23:0] obs1 [14];
      logic [23:0] sym;
      int n;
      rst_n = 1'b0;
      wren  = 1'b0;
      addr  = 6'd0;
      par   = 24'd0;
      din   = 24'd0;
      valid = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_n = 1'b1;

      // Scenario 1: default L = 4, three back-to-back symbols
`ifdef UPS_ZOH_EN
      exp1 = '{24'sd0, 24'sd100, 24'sd100, 24'sd100, 24'sd100, -24'sd200, -24'sd200,
               -24'sd200, -24'sd200, 24'sd300, 24'sd300, 24'sd300, 24'sd300, 24'sd0};
`else
      exp1 = '{24'sd0, 24'sd100, 24'sd0, 24'sd0, 24'sd0, -24'sd200, 24'sd0,
               24'sd0, 24'sd0, 24'sd300, 24'sd0, 24'sd0, 24'sd0, 24'sd0};
`endif
      step("s1_prime", 1'b0, 24'd0, 1'b0, 6'd0, 24'd0);
      for (int i = 0; i < 14; i++) begin
         if (i == 0)      sym = 24'd100;
         else if (i == 1) sym = 24'hFFFF38;
         else             sym = 24'd300;
         step("s1", (i < 3), sym, 1'b0, 6'd0, 24'd0);
         obs1[i] = dout;
      end
      for (int i = 0; i < 14; i++) begin
         checks++;
         assert (obs1[i] === 24'(exp1[i])) else begin
            errors++;
            $error("FAIL s1_seq[%0d]: got %0d expected %0d", i, $signed(obs1[i]), exp1[i]);
         end
      end
      checks++;
      assert (underrun === 1'b1) else begin
         errors++;
         $error("FAIL s1_underrun: got %0b expected 1", underrun);
      end
      repeat (3) step("s1_tail", 1'b0, 24'd0, 1'b0, 6'd0, 24'd0);

      // Scenario 2: reprogram L = 2 while running at L = 4
      for (int i = 0; i < 14; i++) begin
         step("s2", (i < 5), 24'(1000 + i), (i == 3), 6'd63, 24'd2);
      end

      // Scenario 3: pass-through with L = 0, valid held
      step("s3_wr", 1'b0, 24'd0, 1'b1, 6'd63, 24'd0);
      for (int i = 1; i <= 20; i++) step("s3", 1'b1, 24'(i), 1'b0, 6'd0, 24'd0);
      repeat (4) step("s3_tail", 1'b0, 24'd0, 1'b0, 6'd0, 24'd0);

      // Scenario 4: backpressure at L = 4, valid held
      step("s4_wr", 1'b0, 24'd0, 1'b1, 6'd63, 24'd4);
      for (int i = 0; i < 40; i++) step("s4", 1'b1, 24'(5000 + i), 1'b0, 6'd0, 24'd0);
      repeat (12) step("s4_drain", 1'b0, 24'd0, 1'b0, 6'd0, 24'd0);

      // Randomized traffic with occasional bus writes (some to other addresses)
      for (int i = 0; i < 400; i++) begin
         bit v;
         bit wr;
         logic [5:0] a;
         v  = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 19) == 0);
         a  = ($urandom_range(0, 1) == 0) ? 6'd63 : 6'($urandom_range(0, 62));
         step("rand", v, 24'($urandom), wr, a, 24'($urandom_range(0, 6)) | 24'($urandom) << 4);
      end
      step("rand_wr", 1'b0, 24'd0, 1'b1, 6'd63, 24'd7);
      repeat (16) step("rand_drain", 1'b0, 24'd0, 1'b0, 6'd0, 24'd0);

      // Scenario 5: reset mid-period with full FIFO at L = 3
      step("s5_wr", 1'b0, 24'd0, 1'b1, 6'd63, 24'd3);
      for (int i = 0; i < 6; i++) step("s5_fill", 1'b1, 24'(7000 + i), 1'b0, 6'd0, 24'd0);
      n = q.size();
      #2;
      rst_n = 1'b0;
      valid = 1'b0;
      #1;
      check_reset_outputs("s5_async_reset");
      model_reset();
      checks++;
      assert (n == 2) else begin
         errors++;
         $error("FAIL s5_fifo_full_before_reset: got %0d expected 2", n);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step("s5_idle", 1'b0, 24'd0, 1'b0, 6'd0, 24'd0);
      for (int i = 0; i < 14; i++) step("s5_l4", (i < 3), 24'(8000 + i), 1'b0, 6'd0, 24'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
